// File: rtl/perf_monitor.sv
// Performance monitor: NUM_EVT event counters plus a free-running cycle
// counter, with halt/timeout freeze, sticky overflow flags and a registered
// readout mux.
// Build option: define PERF_MONITOR_SAT_EN to make counters saturate at
// all-ones instead of wrapping to zero. Overflow flags behave the same either way.
module perf_monitor #(
    parameter int          NUM_EVT = 4,
    parameter int          CNT_W   = 32,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               halt_i,
    input  logic               clr_i,
    input  logic [3:0]         rd_sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic [1:0]         state_o,
    output logic [NUM_EVT:0]   ovf_o
);

    localparam logic [1:0] ST_COUNT   = 2'b00;
    localparam logic [1:0] ST_HALTED  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Next value of a counter that is being asked to increment.
    function automatic logic [CNT_W-1:0] cnt_next_f(input logic [CNT_W-1:0] cur_v);
`ifdef PERF_MONITOR_SAT_EN
        if (cur_v == CNT_MAX) begin
            return CNT_MAX;
        end else begin
            return cur_v + CNT_ONE;
        end
`else
        return cur_v + CNT_ONE;
`endif
    endfunction

    logic [NUM_EVT-1:0][CNT_W-1:0] evt_cnt_r;
    logic [NUM_EVT-1:0][CNT_W-1:0] evt_cnt_s;
    logic [CNT_W-1:0]              cyc_cnt_r;
    logic [CNT_W-1:0]              cyc_cnt_s;
    logic [1:0]                    state_r;
    logic [1:0]                    state_s;
    logic [NUM_EVT:0]              ovf_r;
    logic [NUM_EVT:0]              ovf_s;
    logic [CNT_W-1:0]              rd_data_r;
    logic [CNT_W-1:0]              rd_mux_s;

    // Counter, overflow and state update for the coming edge.
    always_comb begin
        evt_cnt_s = evt_cnt_r;
        cyc_cnt_s = cyc_cnt_r;
        ovf_s     = ovf_r;
        state_s   = state_r;
        if (clr_i) begin
            // Clear wins over halt, timeout and events in the same cycle.
            evt_cnt_s = {(NUM_EVT*CNT_W){1'b0}};
            cyc_cnt_s = CNT_ZERO;
            ovf_s     = {(NUM_EVT+1){1'b0}};
            state_s   = ST_COUNT;
        end else if (state_r == ST_COUNT) begin
            cyc_cnt_s      = cnt_next_f(cyc_cnt_r);
            ovf_s[NUM_EVT] = ovf_r[NUM_EVT] | (cyc_cnt_r == CNT_MAX);
            for (int i = 0; i < NUM_EVT; i++) begin
                evt_cnt_s[i] = evt_i[i] ? cnt_next_f(evt_cnt_r[i]) : evt_cnt_r[i];
                ovf_s[i]     = ovf_r[i] | (evt_i[i] & (evt_cnt_r[i] == CNT_MAX));
            end
            // Halt has priority over a timeout reached on the same edge. The
            // compare is done at 32 bits so an out-of-range limit never fires.
            if (halt_i) begin
                state_s = ST_HALTED;
            end else if (32'(cyc_cnt_s) == TIMEOUT) begin
                state_s = ST_TIMEOUT;
            end else begin
                state_s = ST_COUNT;
            end
        end else begin
            // HALTED / TIMEOUT: everything frozen until clear or reset.
            state_s = state_r;
        end
    end

    // Readout mux over the current (pre-update) counter values.
    always_comb begin
        rd_mux_s = CNT_ZERO;
        for (int i = 0; i < NUM_EVT; i++) begin
            rd_mux_s = rd_mux_s | ((rd_sel == 4'(i)) ? evt_cnt_r[i] : CNT_ZERO);
        end
        rd_mux_s = rd_mux_s | ((rd_sel == 4'(NUM_EVT)) ? cyc_cnt_r : CNT_ZERO);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_cnt_r <= {(NUM_EVT*CNT_W){1'b0}};
            cyc_cnt_r <= CNT_ZERO;
            ovf_r     <= {(NUM_EVT+1){1'b0}};
            state_r   <= ST_COUNT;
            rd_data_r <= CNT_ZERO;
        end else begin
            evt_cnt_r <= evt_cnt_s;
            cyc_cnt_r <= cyc_cnt_s;
            ovf_r     <= ovf_s;
            state_r   <= state_s;
            rd_data_r <= rd_mux_s;
        end
    end

    assign rd_data = rd_data_r;
    assign state_o = state_r;
    assign ovf_o   = ovf_r;

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 The block SHALL have parameter NUM_EVT, default 4, the number of event counter channels (1..15).
REQ-002 The block SHALL have parameter CNT_W, default 32, the width of every counter (8..32).
REQ-003 The block SHALL have parameter TIMEOUT, default 100000, the watchdog limit in counted cycles (1..2^CNT_W-1).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-006 The block SHALL have port evt_i, input, NUM_EVT, per-channel event strobes (retire, I-cache req/hit, D-cache req/hit, ...).
REQ-007 The block SHALL have port halt_i, input, 1, processor halt indication.
REQ-008 The block SHALL have port clr_i, input, 1, synchronous counter clear and restart.
REQ-009 The block SHALL have port rd_sel, input, 4, readout select: 0..NUM_EVT-1 selects an event counter, NUM_EVT selects the cycle counter.
REQ-010 The block SHALL have port rd_data, output, CNT_W, registered readout value.
REQ-011 The block SHALL have port state_o, output, 2, current state: 00 COUNT, 01 HALTED, 10 TIMEOUT.
REQ-012 The block SHALL have port ovf_o, output, NUM_EVT+1, sticky overflow flags; bit NUM_EVT is the cycle counter.

Function
REQ-013 In COUNT the cycle counter SHALL increment by 1 every cycle, and event counter i SHALL increment by 1 in every cycle with evt_i[i]=1.
REQ-014 In HALTED and TIMEOUT all counters SHALL hold their values.
REQ-015 When halt_i=1 in COUNT, that cycle's increments SHALL still be applied and the state SHALL be HALTED after the edge.
REQ-016 When the cycle counter increments to a value equal to TIMEOUT in COUNT, the state SHALL be TIMEOUT after that same edge.
REQ-017 If halt_i=1 and the timeout condition occur in the same cycle, HALTED SHALL take priority.
REQ-018 HALTED and TIMEOUT SHALL be exited only by clr_i or reset; halt_i has no effect outside COUNT.
REQ-019 A cycle with clr_i=1 in any state SHALL zero all counters and ovf_o and enter COUNT; clr_i overrides halt_i, timeout and events in that cycle, and no increment occurs.
REQ-020 rd_data SHALL equal, one cycle after sampling, the selected counter value as it stood before that edge's update.
REQ-021 An rd_sel value greater than NUM_EVT SHALL give rd_data = 0.
REQ-022 An increment attempted with a counter at 2^CNT_W-1 SHALL set that counter's ovf_o bit, which stays set until clr_i or reset.
REQ-023 Counter arithmetic SHALL be unsigned at CNT_W bits, with no cross-channel interaction.

Reset
REQ-024 A rising edge with rst_n=0 SHALL set all counters to 0, ovf_o to 0, rd_data to 0 and state_o to COUNT.
REQ-025 Counting SHALL begin at the first rising edge with rst_n=1.
REQ-026 Reset SHALL override clr_i, halt_i and evt_i, including when asserted mid-run or in HALTED/TIMEOUT.

Configuration
REQ-027 With macro PERF_MONITOR_SAT_EN defined, a counter at 2^CNT_W-1 SHALL saturate and hold that value on further increments.
REQ-028 Without PERF_MONITOR_SAT_EN, such a counter SHALL wrap to 0.
REQ-029 The ovf_o behaviour of REQ-022 SHALL be identical in both builds.

Verification
REQ-030 Reset, then 10 cycles with evt_i=4'b0011 then halt_i=1 -> state_o=01; cycle counter=11; ch0=ch1=11; ch2=ch3=0; counters frozen afterwards.
REQ-031 TIMEOUT=16, no halt -> state_o=10 after 16 counted cycles; cycle counter reads 16 and stays 16.
REQ-032 TIMEOUT=16 and halt_i=1 on the 16th cycle -> state_o=01 (halt priority); cycle counter=16.
REQ-033 CNT_W=8, evt_i[0] high for 300 cycles -> ch0 reads 255 with PERF_MONITOR_SAT_EN and 44 without; ovf_o[0]=1 in both builds.
REQ-034 In HALTED, assert clr_i together with halt_i -> next cycle all counters 0, ovf_o=0, state_o=00, counting resumes.
REQ-035 rd_sel=NUM_EVT+3 -> rd_data=0; rst_n=0 for 1 cycle mid-run -> all outputs 0 and state_o=00 on the next edge.
